// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_mp_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // One read port as seen by decode: address in, data and readiness out.
  typedef struct packed {
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
    logic                ready;
  } rd_port_t;

  // One writeback port.
  typedef struct packed {
    logic                en;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW:0]         busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_ready, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_ready, busy_count
  );

endinterface

// File: rtl/regfile_mp_rf_scoreboard.sv
// Pending-result scoreboard: one bit per register, set on issue, cleared on
// writeback, with a registered population count of the pending bits.
module rf_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  // One one-hot clear row per write port, row j at [j*NREGS +: NREGS].
  input  logic [NWR*NREGS-1:0] clr_vec,
  output logic [NREGS-1:0]     pending,
  output logic [AW:0]          busy_count
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW:0]      busy_q, busy_d;
  logic [NREGS-1:0] clr_any;
  logic [NREGS-1:0] set_vec;

  // Next pending vector: clears first, then the issue on top because it is newer.
  always_comb begin
    clr_any = '0;
    for (int j = 0; j < NWR; j++) begin
      clr_any = clr_any | clr_vec[j*NREGS +: NREGS];
    end
    set_vec = '0;
    if (iss_en) begin
      set_vec[iss_addr] = 1'b1;
    end
    pending_d = (pending_q & ~clr_any) | set_vec;
    if (ZERO_REG != 0) begin
      pending_d[0] = 1'b0;
    end
  end

  // Population count of the next pending vector, so the count tracks the bits.
  always_comb begin
    busy_d = '0;
    for (int k = 0; k < NREGS; k++) begin
      busy_d = busy_d + {{AW{1'b0}}, pending_d[k]};
    end
  end

  // Pending bits and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign pending    = pending_q;
  assign busy_count = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional zero register, optional
// write-to-read bypass and a pending scoreboard for RAW hazard detection.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]      regs_q [NREGS];
  logic [XLEN-1:0]      regs_d [NREGS];
  logic [NWR*NREGS-1:0] clr_vec;
  logic [NREGS-1:0]     pending;
  logic [NRD*XLEN-1:0]  rd_data_c;
  logic [NRD-1:0]       rd_ready_c;
  logic [AW-1:0]        wa;
  logic [NREGS-1:0]     clr_row;
  logic [AW-1:0]        ra;
  logic [XLEN-1:0]      rdat;
  logic                 rrdy;

  // Write priority: ports applied in ascending order so the highest index wins;
  // every write also produces a clear row for the scoreboard.
  always_comb begin
    wa      = '0;
    clr_row = '0;
    clr_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int j = 0; j < NWR; j++) begin
      wa = bus.wr_addr[j*AW +: AW];
      if (bus.wr_en[j] && !(ZERO_REG != 0 && wa == '0)) begin
        regs_d[wa] = bus.wr_data[j*XLEN +: XLEN];
      end
      clr_row     = '0;
      clr_row[wa] = bus.wr_en[j];
      clr_vec[j*NREGS +: NREGS] = clr_row;
    end
  end

  // Storage array; reset clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .iss_en     (bus.iss_en),
    .iss_addr   (bus.iss_addr),
    .clr_vec    (clr_vec),
    .pending    (pending),
    .busy_count (bus.busy_count)
  );

  // Read muxes: stored value, then bypass (highest write port wins), then the
  // zero register overriding everything. Bypass is gated by reset so the
  // outputs are purely the cleared state while rst is high.
  always_comb begin
    ra         = '0;
    rdat       = '0;
    rrdy       = 1'b0;
    rd_data_c  = '0;
    rd_ready_c = '0;
    for (int i = 0; i < NRD; i++) begin
      ra   = bus.rd_addr[i*AW +: AW];
      rdat = regs_q[ra];
      rrdy = !pending[ra];
      if (BYPASS != 0 && !rst) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) begin
            rdat = bus.wr_data[j*XLEN +: XLEN];
            rrdy = 1'b1;
          end
        end
      end
      if (ZERO_REG != 0 && ra == '0) begin
        rdat = '0;
        rrdy = 1'b1;
      end
      rd_data_c[i*XLEN +: XLEN] = rdat;
      rd_ready_c[i]             = rrdy;
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_ready = rd_ready_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dut_a is the two-write-port, bypassing configuration;
// dut_b is the single-write-port configuration without bypass.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) if_a ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1)) if_b ();

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  logic [31:0] a_rd0, a_rd1, b_rd0;
  assign a_rd0 = if_a.rd_data[31:0];
  assign a_rd1 = if_a.rd_data[63:32];
  assign b_rd0 = if_b.rd_data[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_port_t mk(input logic en, input int addr, input logic [31:0] data);
    wr_port_t p;
    p.en   = en;
    p.addr = 5'(addr);
    p.data = data;
    return p;
  endfunction

  task automatic drive_a(input wr_port_t p1, input wr_port_t p0);
    if_a.wr_en   = {p1.en, p0.en};
    if_a.wr_addr = {p1.addr, p0.addr};
    if_a.wr_data = {p1.data, p0.data};
  endtask

  task automatic idle_a();
    if_a.wr_en  = '0;
    if_a.iss_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    if_a.rd_addr = '0; if_a.wr_en = '0; if_a.wr_addr = '0; if_a.wr_data = '0;
    if_a.iss_en = 1'b0; if_a.iss_addr = '0;
    if_b.rd_addr = '0; if_b.wr_en = '0; if_b.wr_addr = '0; if_b.wr_data = '0;
    if_b.iss_en = 1'b0; if_b.iss_addr = '0;

    // Power-on reset, checked without a clock edge.
    #1 rst = 1'b1;
    #1;
    if_a.rd_addr = {5'd1, 5'd5};
    #1;
    chk("reset_data", {32'd0, a_rd0}, 64'd0);
    chk("reset_ready", {62'd0, if_a.rd_ready}, 64'h3);
    chk("reset_busy", {58'd0, if_a.busy_count}, 64'd0);
    tick();
    rst = 1'b0;

    // Write reg5 and issue reg6, then reset mid-run.
    drive_a(mk(0, 0, 0), mk(1, 5, 32'hDEADBEEF));
    if_a.iss_en = 1'b1; if_a.iss_addr = 5'd6;
    tick();
    idle_a();
    if_a.rd_addr = {5'd6, 5'd5};
    #1;
    chk("pre_rst_data5", {32'd0, a_rd0}, 64'hDEADBEEF);
    chk("pre_rst_ready6", {63'd0, if_a.rd_ready[1]}, 64'd0);
    chk("pre_rst_busy", {58'd0, if_a.busy_count}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_data5", {32'd0, a_rd0}, 64'd0);
    chk("midrst_ready", {62'd0, if_a.rd_ready}, 64'h3);
    chk("midrst_busy", {58'd0, if_a.busy_count}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Bypass on dut_a, no bypass on dut_b.
    drive_a(mk(0, 0, 0), mk(1, 7, 32'h12345678));
    if_a.rd_addr = {5'd0, 5'd7};
    if_b.wr_en = 1'b1; if_b.wr_addr = 5'd7; if_b.wr_data = 32'h12345678;
    if_b.rd_addr = 5'd7;
    #1;
    chk("bypass_data", {32'd0, a_rd0}, 64'h12345678);
    chk("bypass_ready", {63'd0, if_a.rd_ready[0]}, 64'd1);
    chk("nobypass_old", {32'd0, b_rd0}, 64'd0);
    tick();
    idle_a();
    if_b.wr_en = 1'b0;
    #1;
    chk("nobypass_next", {32'd0, b_rd0}, 64'h12345678);
    chk("bypass_stored", {32'd0, a_rd0}, 64'h12345678);

    // dut_b: issue reg4, then a same-cycle write must not raise ready.
    if_b.iss_en = 1'b1; if_b.iss_addr = 5'd4;
    tick();
    if_b.iss_en = 1'b0;
    if_b.rd_addr = 5'd4;
    if_b.wr_en = 1'b1; if_b.wr_addr = 5'd4; if_b.wr_data = 32'h77;
    #1;
    chk("nobypass_ready_low", {63'd0, if_b.rd_ready[0]}, 64'd0);
    tick();
    if_b.wr_en = 1'b0;
    #1;
    chk("nobypass_ready_after", {63'd0, if_b.rd_ready[0]}, 64'd1);
    chk("nobypass_busy_after", {58'd0, if_b.busy_count}, 64'd0);

    // Zero register: write and issue reg0.
    drive_a(mk(0, 0, 0), mk(1, 0, 32'hFFFFFFFF));
    if_a.iss_en = 1'b1; if_a.iss_addr = 5'd0;
    if_a.rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_comb_data", {32'd0, a_rd0}, 64'd0);
    tick();
    idle_a();
    #1;
    chk("zero_data", {32'd0, a_rd0}, 64'd0);
    chk("zero_ready", {63'd0, if_a.rd_ready[0]}, 64'd1);
    chk("zero_busy", {58'd0, if_a.busy_count}, 64'd0);

    // Scoreboard on reg3.
    if_a.iss_en = 1'b1; if_a.iss_addr = 5'd3;
    tick();
    idle_a();
    if_a.rd_addr = {5'd0, 5'd3};
    #1;
    chk("sb_issue_ready", {63'd0, if_a.rd_ready[0]}, 64'd0);
    chk("sb_issue_busy", {58'd0, if_a.busy_count}, 64'd1);
    drive_a(mk(0, 0, 0), mk(1, 3, 32'hA5));
    #1;
    chk("sb_wr_bypass_ready", {63'd0, if_a.rd_ready[0]}, 64'd1);
    chk("sb_wr_bypass_data", {32'd0, a_rd0}, 64'hA5);
    tick();
    idle_a();
    #1;
    chk("sb_clr_ready", {63'd0, if_a.rd_ready[0]}, 64'd1);
    chk("sb_clr_busy", {58'd0, if_a.busy_count}, 64'd0);
    chk("sb_clr_data", {32'd0, a_rd0}, 64'hA5);
    drive_a(mk(0, 0, 0), mk(1, 3, 32'h5A));
    if_a.iss_en = 1'b1; if_a.iss_addr = 5'd3;
    tick();
    idle_a();
    #1;
    chk("sb_isswr_ready", {63'd0, if_a.rd_ready[0]}, 64'd0);
    chk("sb_isswr_busy", {58'd0, if_a.busy_count}, 64'd1);
    chk("sb_isswr_data", {32'd0, a_rd0}, 64'h5A);
    drive_a(mk(0, 0, 0), mk(1, 3, 32'h5A));
    tick();
    idle_a();
    #1;
    chk("sb_final_busy", {58'd0, if_a.busy_count}, 64'd0);

    // Dual write, same address: port1 wins (bypass and storage).
    drive_a(mk(1, 9, 32'h2), mk(1, 9, 32'h1));
    if_a.rd_addr = {5'd0, 5'd9};
    #1;
    chk("dual_same_bypass", {32'd0, a_rd0}, 64'h2);
    tick();
    idle_a();
    #1;
    chk("dual_same_stored", {32'd0, a_rd0}, 64'h2);
    drive_a(mk(1, 10, 32'hBB), mk(1, 9, 32'hAA));
    tick();
    idle_a();
    if_a.rd_addr = {5'd10, 5'd9};
    #1;
    chk("dual_diff_r9", {32'd0, a_rd0}, 64'hAA);
    chk("dual_diff_r10", {32'd0, a_rd1}, 64'hBB);

    // Full scoreboard: issue regs 1..31.
    for (int r = 1; r < 32; r++) begin
      if_a.iss_en = 1'b1; if_a.iss_addr = 5'(r);
      tick();
    end
    idle_a();
    #1;
    chk("full_busy", {58'd0, if_a.busy_count}, 64'd31);
    for (int r = 0; r < 32; r++) begin
      if_a.rd_addr = {5'd0, 5'(r)};
      #1;
      chk($sformatf("full_ready_r%0d", r), {63'd0, if_a.rd_ready[0]}, (r == 0) ? 64'd1 : 64'd0);
    end

    // Drain two registers per cycle.
    for (int k = 0; k < 16; k++) begin
      int a0, a1, exp_busy;
      a0 = 2*k + 1;
      a1 = 2*k + 2;
      drive_a(mk((a1 <= 31), (a1 <= 31) ? a1 : 0, 32'(a1)), mk(1, a0, 32'(a0)));
      tick();
      exp_busy = 31 - 2*(k + 1);
      if (exp_busy < 0) exp_busy = 0;
      idle_a();
      #1;
      chk($sformatf("drain_busy_%0d", k), {58'd0, if_a.busy_count}, 64'(exp_busy));
    end
    if_a.rd_addr = {5'd30, 5'd31};
    #1;
    chk("drain_ready", {62'd0, if_a.rd_ready}, 64'h3);
    chk("drain_data31", {32'd0, a_rd0}, 64'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the core's decode/writeback path.
- Generalises the single-write, two-read register file with four additions:
  - configurable width, depth and port counts;
  - optional hardwired zero register;
  - optional write-to-read bypass;
  - per-register pending scoreboard, so decode can detect RAW hazards on in-flight results.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, at least 2.
- AW, $clog2(NREGS), address width (derived; not overridden).
- NRD, 2, number of read ports (1..4).
- NWR, 1, number of write ports (1..2).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, when 1 same-cycle write data is forwarded to matching reads.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies slice [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_ready  out  NRD  1 = register value valid (not pending, or resolved by bypass).
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue: mark iss_addr pending (destination of an in-flight instruction).
- iss_addr  in  AW  destination register being issued.
- busy_count  out  AW+1  number of currently pending registers.

Behaviour:
- Reset (async, rst=1): all registers clear to 0; all pending bits clear; busy_count=0.
  - Outputs are combinational from state, so during reset: rd_data=0 and rd_ready all 1.
  - Deasserting rst mid-operation discards any in-flight issue; no write is taken while rst=1.
- Read path: combinational, zero latency.
  - Without a matching write: rd_data[i] = reg[rd_addr[i]].
  - BYPASS=1 and some wr_en[j] with wr_addr[j]==rd_addr[i]:
    - rd_data[i] = that write's wr_data; rd_ready[i]=1.
    - If two write ports match, the highest index wins.
  - BYPASS=0: new data is visible the cycle after the write edge.
  - ZERO_REG=1 and rd_addr[i]==0: rd_data=0 and rd_ready=1 regardless of writes.
- Write path: at the clock edge, every asserted wr_en[j] updates reg[wr_addr[j]].
  - Two ports writing the same address: highest index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Scoreboard (one pending bit per register):
  - A write to a register clears its pending bit at the edge.
  - iss_en sets pending[iss_addr] at the edge.
  - Issue and write to the same register in the same cycle: pending ends set, because the issue is newer.
  - Issue to an already-pending register: stays set, no error.
  - Write to a non-pending register: pending stays 0, data written.
  - ZERO_REG=1: issue to register 0 is ignored.
- rd_ready[i] = !pending[rd_addr[i]], or a bypass hit (BYPASS=1), or the zero-register case.
  - With BYPASS=0 a same-cycle write does not raise rd_ready.
- busy_count: registered population count of the pending bits, updated the same edge as the pending bits.
  - Range 0..NREGS; hence AW+1 bits.
- No X propagation: all storage is reset, and out-of-range addresses cannot occur because the depth is a power of two.

Decomposition:
- Shared package Bundle holds:
  - typedefs for the read-port and write-port structs (addr, data, en);
  - the default XLEN/NREGS constants.
- One natural sub-module, rf_scoreboard: the pending-bit vector, issue/clear priority and busy_count.
  - Parameters: NREGS, NWR, ZERO_REG.
  - Ports: clk, rst, iss_en, iss_addr, clear vector, pending vector, busy_count.
- regfile_mp holds the storage array, write-priority logic and the read/bypass muxes.

Test Plan:
- Reset mid-run: write reg5=0xDEADBEEF, assert rst for 1 cycle -> rd_data(5)=0, rd_ready=1, busy_count=0 immediately, without waiting for a clock edge.
- Bypass, BYPASS=1: same cycle wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr[0]=7 -> rd_data[0]=0x12345678, rd_ready[0]=1 combinationally.
  - Rerun with BYPASS=0 -> old value 0 that cycle, 0x12345678 the next.
- Zero register: write reg0=0xFFFFFFFF and issue reg0 -> rd_data(0)=0, rd_ready=1, busy_count unchanged.
- Scoreboard: issue reg3 -> next cycle rd_ready for reg3 = 0 and busy_count=1.
  - Write reg3=0xA5 -> that cycle ready via bypass; next cycle pending clear, busy_count=0.
  - Issue and write reg3 together -> pending remains 1, busy_count=1, data=written value.
- Dual write, NWR=2, same address 9: port0 data 0x1, port1 data 0x2 -> reg9=0x2.
  - Different addresses 9/10 -> both written in one edge.
- Full scoreboard, NREGS=32, ZERO_REG=1: issue regs 1..31 on consecutive cycles -> busy_count reaches 31, all rd_ready low except reg0.
  - Clear them all via two write ports -> count falls by 2 per cycle down to 0.
